// File: rtl/mem_bus_pkg.sv
// Shared constants for mem_bus: IO register offsets, STATUS bit positions,
// and the serializer state encoding.
package mem_bus_pkg;
  localparam logic [15:0] TXDATA_OFF = 16'h0000;
  localparam logic [15:0] STATUS_OFF = 16'h0002;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_IRQ_EN = 4;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;
endpackage

// File: rtl/mem_bus_uart_tx.sv
// 8N1 serializer: latches a byte on load while idle and shifts it out LSB
// first with a registered tx line, BAUD_DIV clocks per bit.
module uart_tx
  import mem_bus_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       busy,
  output logic       tx
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: if (load) begin
        state_d = S_START;
        shift_d = byte_in;
        baud_d  = '0;
        tx_d    = 1'b0;
      end
      S_START: if (baud_end) begin
        state_d = S_DATA;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end else baud_d = baud_q + CW'(1);
      // tx leads the shift register by one: it shows the bit about to be consumed
      S_DATA: if (baud_end) begin
        baud_d = '0;
        if (bit_q == 3'd7) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          bit_d   = bit_q + 3'd1;
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end else baud_d = baud_q + CW'(1);
      S_STOP: if (baud_end) begin
        state_d = S_IDLE;
        baud_d  = '0;
      end else baud_d = baud_q + CW'(1);
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign tx   = tx_q;
endmodule

// File: rtl/mem_bus.sv
// Memory/IO stage: word RAM with byte lanes plus a TX FIFO feeding uart_tx.
// Optional tx_irq output and STATUS irq_en bit under `MEM_BUS_TX_IRQ_EN.
module mem_bus
  import mem_bus_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int          BAUD_DIV   = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] RAMaddr,
  input  logic [15:0] RAMin,
  input  logic        we,
  input  logic        be,
  output logic [15:0] RAMout,
  output logic        tx,
  output logic        tx_busy
`ifdef MEM_BUS_TX_IRQ_EN
  , output logic      tx_irq
`endif
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [15:0] TXDATA_ADDR = IO_BASE + TXDATA_OFF;
  localparam logic [15:0] STATUS_ADDR = IO_BASE + STATUS_OFF;

  logic [15:0] ram_q [MEM_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            irq_en;

  logic [AW-1:0] widx;
  logic [15:0]   word, status;
  logic          is_io, tx_wr, st_wr, full, empty, pop, push_ok;

  assign widx  = RAMaddr[AW:1];
  assign word  = ram_q[widx];
  assign is_io = (RAMaddr >= IO_BASE);
  assign tx_wr = we && (RAMaddr == TXDATA_ADDR);
  assign st_wr = we && (RAMaddr == STATUS_ADDR);

  assign full    = (count_q == CNTW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = !tx_busy && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = tx_wr && (!full || pop);

  always_comb begin
    status            = '0;
    status[ST_FULL]   = full;
    status[ST_EMPTY]  = empty;
    status[ST_BUSY]   = tx_busy;
    status[ST_OVF]    = ovf_q;
    status[ST_IRQ_EN] = irq_en;
    RAMout = '0;
    if (!is_io) RAMout = be ? {8'h00, (RAMaddr[0] ? word[15:8] : word[7:0])} : word;
    else if (RAMaddr == STATUS_ADDR) RAMout = status;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CNTW'(push_ok) - CNTW'(pop);
    ovf_d    = ovf_q;
    if (st_wr && RAMin[ST_OVF]) ovf_d = 1'b0;
    if (tx_wr && full && !pop)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we && !is_io) begin
      if (!be)             ram_q[widx]       <= RAMin;
      else if (RAMaddr[0]) ram_q[widx][15:8] <= RAMin[7:0];
      else                 ram_q[widx][7:0]  <= RAMin[7:0];
    end
    if (push_ok) fifo_q[wr_ptr_q] <= RAMin[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef MEM_BUS_TX_IRQ_EN
  logic irq_en_q, irq_en_d, tx_irq_q, tx_irq_d;
  always_comb begin
    irq_en_d = st_wr ? RAMin[ST_IRQ_EN] : irq_en_q;
    tx_irq_d = irq_en_q && empty && !tx_busy;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      tx_irq_q <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      tx_irq_q <= tx_irq_d;
    end
  end
  assign irq_en = irq_en_q;
  assign tx_irq = tx_irq_q;
`else
  assign irq_en = 1'b0;
`endif

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk    (clk),
    .reset  (reset),
    .load   (pop),
    .byte_in(fifo_q[rd_ptr_q]),
    .busy   (tx_busy),
    .tx     (tx)
  );
endmodule

// File: tb/tb_mem_bus.sv
// Directed bench for mem_bus: RAM vector table plus serial frame, overflow,
// reset-abort and (with MEM_BUS_TX_IRQ_EN) interrupt sequences.
module tb_mem_bus;
  logic        clk = 1'b0;
  logic        reset, we, be;
  logic [15:0] RAMaddr, RAMin, RAMout;
  logic        tx, tx_busy;
`ifdef MEM_BUS_TX_IRQ_EN
  logic        tx_irq;
`endif

  int applied = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  mem_bus #(.MEM_WORDS(1024), .IO_BASE(16'hFF00), .BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .RAMaddr(RAMaddr),
    .RAMin  (RAMin),
    .we     (we),
    .be     (be),
    .RAMout (RAMout),
    .tx     (tx),
    .tx_busy(tx_busy)
`ifdef MEM_BUS_TX_IRQ_EN
    , .tx_irq(tx_irq)
`endif
  );

  typedef struct {
    logic        we;
    logic        be;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       exp_tx;
    logic [7:0] fbyte;
    reset = 1'b1; we = 1'b0; be = 1'b0; RAMaddr = '0; RAMin = '0;

    tbl[0]  = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 16'h0011, 16'h0012, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h12EF};
    tbl[3]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h00EF};
    tbl[4]  = '{1'b0, 1'b1, 16'h0011, 16'h0000, 16'h0012};
    tbl[5]  = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h12EF};
    tbl[6]  = '{1'b1, 1'b0, 16'h0800, 16'hCAFE, 16'h0000};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hCAFE};
    tbl[8]  = '{1'b1, 1'b1, 16'h0000, 16'h0077, 16'h0000};
    tbl[9]  = '{1'b0, 1'b0, 16'h0800, 16'h0000, 16'hCA77};
    tbl[10] = '{1'b1, 1'b0, 16'h0704, 16'h5555, 16'h0000};
    tbl[11] = '{1'b1, 1'b0, 16'hFF04, 16'hAAAA, 16'h0000};
    tbl[12] = '{1'b0, 1'b0, 16'h0704, 16'h0000, 16'h5555};
    tbl[13] = '{1'b1, 1'b0, 16'hFEFE, 16'h1234, 16'h0000};
    tbl[14] = '{1'b0, 1'b1, 16'h06FF, 16'h0000, 16'h0012};
    tbl[15] = '{1'b0, 1'b0, 16'hFF00, 16'h0000, 16'h0000};
    tbl[16] = '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h0002};
    tbl[17] = '{1'b0, 1'b0, 16'hFF06, 16'h0000, 16'h0000};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx", {15'b0, tx}, 16'h0001);
    chk("reset_busy", {15'b0, tx_busy}, 16'h0000);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      we = tbl[i].we; be = tbl[i].be; RAMaddr = tbl[i].addr; RAMin = tbl[i].din;
      #1;
      if (!tbl[i].we) chk($sformatf("ram_vec%0d", i), RAMout, tbl[i].exp);
    end
    @(negedge clk) we = 1'b0; be = 1'b0;

    // single frame of 8'hA5
    fbyte = 8'hA5;
    @(negedge clk) we = 1'b1; RAMaddr = 16'hFF00; RAMin = 16'h00A5;
    @(posedge clk) #1;
    chk("frame_push_tx", {15'b0, tx}, 16'h0001);
    chk("frame_push_busy", {15'b0, tx_busy}, 16'h0000);
    @(negedge clk) we = 1'b0; RAMaddr = 16'h0000;
    @(posedge clk) #1;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (c < 4)       exp_tx = 1'b0;
      else if (c < 36) exp_tx = fbyte[(c - 4) / 4];
      else             exp_tx = 1'b1;
      chk($sformatf("frame_tx_c%0d", c), {15'b0, tx}, {15'b0, exp_tx});
      chk($sformatf("frame_busy_c%0d", c), {15'b0, tx_busy}, {15'b0, (c < 40)});
    end

    // overflow: 6 back-to-back pushes while idle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) we = 1'b1; RAMaddr = 16'hFF00; RAMin = 16'h0010 + 16'(i);
    end
    @(negedge clk) we = 1'b0; RAMaddr = 16'hFF02;
    #1 chk("ovf_status", RAMout, 16'h000D);
    @(negedge clk) we = 1'b1; RAMin = 16'h0008;
    @(negedge clk) we = 1'b0;
    #1 chk("ovf_cleared", RAMout, 16'h0005);

    // reset in the middle of the data bits
    repeat (10) @(negedge clk);
    #1 chk("mid_busy", {15'b0, tx_busy}, 16'h0001);
    reset = 1'b1;
    @(posedge clk) #1;
    chk("abort_tx", {15'b0, tx}, 16'h0001);
    chk("abort_busy", {15'b0, tx_busy}, 16'h0000);
    @(negedge clk) reset = 1'b0;
    #1 chk("abort_status", RAMout, 16'h0002);

`ifdef MEM_BUS_TX_IRQ_EN
    @(negedge clk) we = 1'b1; RAMaddr = 16'hFF02; RAMin = 16'h0010;
    @(negedge clk) we = 1'b0;
    #1 chk("irq_status", RAMout, 16'h0012);
    @(posedge clk) #1 chk("irq_idle", {15'b0, tx_irq}, 16'h0001);
    @(negedge clk) we = 1'b1; RAMaddr = 16'hFF00; RAMin = 16'h0055;
    @(negedge clk) we = 1'b0;
    @(posedge clk) #1 chk("irq_drop", {15'b0, tx_irq}, 16'h0000);
    for (int k = 0; k < 100; k++) begin
      if (!tx_busy) break;
      @(posedge clk);
      #1;
    end
    chk("irq_frame_done", {15'b0, tx_busy}, 16'h0000);
    @(posedge clk) #1 chk("irq_back", {15'b0, tx_irq}, 16'h0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end
endmodule
